// File: rtl/pcie_byte_link.sv
// Byte-to-byte serial link: TX serializes DATA onto serial_out, RX deserializes serial_in.
// Optional even parity bit after the MSB when the PARITY_EN macro is defined.
module pcie_byte_link #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [DATA_W-1:0] DATA,
  input  logic              Valid,
  output logic              tx_ready,
  output logic              serial_out,
  input  logic              serial_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              framing_err,
  output logic              parity_err
);

  localparam int unsigned CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } st_t;

  // ---------------- TX ----------------
  st_t              tx_st, tx_st_nxt;
  logic [CW-1:0]    tx_cnt, tx_cnt_nxt;
  logic [DATA_W-1:0] tx_byte;
  logic             accept;
  logic             serial_nxt;
  logic             tx_ready_nxt;

  assign accept = Valid && tx_ready;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      tx_st      <= S_IDLE;
      tx_cnt     <= '0;
      tx_byte    <= '0;
      serial_out <= 1'b1;
      tx_ready   <= 1'b1;
    end else begin
      tx_st      <= tx_st_nxt;
      tx_cnt     <= tx_cnt_nxt;
      serial_out <= serial_nxt;
      tx_ready   <= tx_ready_nxt;
      if (accept) begin
        tx_byte <= DATA;
      end
    end
  end

  always_comb begin
    tx_st_nxt  = tx_st;
    tx_cnt_nxt = '0;
    case (tx_st)
      S_IDLE: begin
        if (accept) tx_st_nxt = S_START;
      end
      S_START: tx_st_nxt = S_DATA;
      S_DATA: begin
        if (tx_cnt == CW'(DATA_W - 1)) begin
`ifdef PARITY_EN
          tx_st_nxt = S_PAR;
`else
          tx_st_nxt = S_STOP;
`endif
        end else begin
          tx_cnt_nxt = tx_cnt + CW'(1);
        end
      end
      S_PAR:  tx_st_nxt = S_STOP;
      S_STOP: tx_st_nxt = accept ? S_START : S_IDLE;
      default: tx_st_nxt = S_IDLE;
    endcase
  end

  // Line level and ready flag follow the state being entered, so both stay registered.
  always_comb begin
    serial_nxt   = 1'b1;
    tx_ready_nxt = 1'b0;
    case (tx_st_nxt)
      S_IDLE:  tx_ready_nxt = 1'b1;
      S_STOP:  tx_ready_nxt = 1'b1;
      S_START: serial_nxt   = 1'b0;
      S_DATA:  serial_nxt   = tx_byte[tx_cnt_nxt];
      S_PAR:   serial_nxt   = ^tx_byte;
      default: serial_nxt   = 1'b1;
    endcase
  end

  // ---------------- RX ----------------
  st_t               rx_st, rx_st_nxt;
  logic [CW-1:0]     rx_cnt, rx_cnt_nxt;
  logic [DATA_W-1:0] rx_sh;
  logic              par_ok;
  logic              valid_nxt;
  logic              ferr_nxt;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      rx_st       <= S_IDLE;
      rx_cnt      <= '0;
      rx_sh       <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      rx_st       <= rx_st_nxt;
      rx_cnt      <= rx_cnt_nxt;
      valid_out   <= valid_nxt;
      framing_err <= ferr_nxt;
      if (rx_st == S_DATA) begin
        rx_sh <= {serial_in, rx_sh[DATA_W-1:1]};
      end
      if (valid_nxt) begin
        data_out <= rx_sh;
      end
    end
  end

`ifdef PARITY_EN
  logic rx_par;

  assign par_ok = ((^rx_sh) == rx_par);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      rx_par     <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (rx_st == S_PAR) begin
        rx_par <= serial_in;
      end
      parity_err <= (rx_st == S_STOP) && !par_ok;
    end
  end
`else
  assign par_ok     = 1'b1;
  assign parity_err = 1'b0;
`endif

  always_comb begin
    rx_st_nxt  = rx_st;
    rx_cnt_nxt = '0;
    case (rx_st)
      S_IDLE: begin
        if (!serial_in) rx_st_nxt = S_DATA;
      end
      S_DATA: begin
        if (rx_cnt == CW'(DATA_W - 1)) begin
`ifdef PARITY_EN
          rx_st_nxt = S_PAR;
`else
          rx_st_nxt = S_STOP;
`endif
        end else begin
          rx_cnt_nxt = rx_cnt + CW'(1);
        end
      end
      S_PAR:   rx_st_nxt = S_STOP;
      // A low stop bit is consumed here, never reused as the next start bit.
      S_STOP:  rx_st_nxt = S_IDLE;
      default: rx_st_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    if (rx_st == S_STOP) begin
      ferr_nxt  = !serial_in;
      valid_nxt = serial_in && par_ok;
    end
  end

endmodule

// File: tb/tb_pcie_byte_link.sv
// Randomized self-checking bench for pcie_byte_link against a frame-level reference model.
// Loopback by default; serial_in can be taken over to inject malformed frames.
module tb_pcie_byte_link;

  localparam int DATA_W = 8;
`ifdef PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME = DATA_W + 2 + PAR;

  logic              CLK = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] DATA;
  logic              Valid;
  logic              tx_ready;
  logic              serial_out;
  logic              serial_in;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              framing_err;
  logic              parity_err;
  logic              inj_en;
  logic              inj_bit;

  assign serial_in = inj_en ? inj_bit : serial_out;

  pcie_byte_link #(.DATA_W(DATA_W)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .DATA       (DATA),
    .Valid      (Valid),
    .tx_ready   (tx_ready),
    .serial_out (serial_out),
    .serial_in  (serial_in),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .framing_err(framing_err),
    .parity_err (parity_err)
  );

  always #5 CLK = ~CLK;

  // Reference model: accepted frames and expected RX events keyed by edge index.
  int                n_chk  = 0;
  int                n_pass = 0;
  int                cyc    = 0;
  int                last_acc  = -1000;
  int                cur_start = -1000;
  int                vcyc   = 0;
  bit                fbits [FRAME];
  logic [DATA_W-1:0] exp_data = '0;
  logic [DATA_W-1:0] lat_byte;
  logic [2:0]        ev_kind [int];  // {valid, framing, parity}
  logic [DATA_W-1:0] ev_byte [int];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at edge %0d: got=%0h expected=%0h", tag, cyc, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    cyc++;
    #1;
  endtask

  task automatic step();
    bit         acc;
    logic [2:0] k;
    logic       exp_line;
    acc = Valid && (cyc >= last_acc + FRAME - 1);
    if (acc) lat_byte = DATA;
    @(posedge CLK);
    cyc++;
    if (acc) begin
      last_acc  = cyc;
      cur_start = cyc;
      fbits[0]  = 1'b0;
      for (int i = 0; i < DATA_W; i++) fbits[1+i] = lat_byte[i];
      if (PAR != 0) fbits[DATA_W+1] = ^lat_byte;
      fbits[FRAME-1] = 1'b1;
      ev_kind[cyc+FRAME] = 3'b100;
      ev_byte[cyc+FRAME] = lat_byte;
    end
    #1;
    k = ev_kind.exists(cyc) ? ev_kind[cyc] : 3'b000;
    if (k[2]) exp_data = ev_byte[cyc];
    if (cyc >= cur_start && cyc < cur_start + FRAME) exp_line = fbits[cyc-cur_start];
    else exp_line = 1'b1;
    check("serial_out", 32'(serial_out), 32'(exp_line));
    check("tx_ready", 32'(tx_ready), 32'(cyc >= last_acc + FRAME - 1));
    check("valid_out", 32'(valid_out), 32'(k[2]));
    check("framing_err", 32'(framing_err), 32'(k[1]));
    check("parity_err", 32'(parity_err), 32'(k[0]));
    check("data_out", 32'(data_out), 32'(exp_data));
  endtask

  task automatic send(input logic [DATA_W-1:0] b);
    int n = 0;
    DATA  = b;
    Valid = 1'b1;
    do begin
      step();
      n++;
    end while (last_acc != cyc && n < 100);
    if (n >= 100) check("accept_timeout", 32'(0), 32'(1));
  endtask

  task automatic drain();
    int n = 0;
    Valid = 1'b0;
    while (cyc < last_acc + FRAME + 1 && n < 200) begin
      step();
      n++;
      if (valid_out) vcyc = cyc;
    end
  endtask

  task automatic inject(input logic [DATA_W-1:0] b, input bit par_good, input bit stop_bit);
    int ev;
    bit pbad;
    ev   = cyc + FRAME;
    pbad = (PAR != 0) && !par_good;
    ev_kind[ev] = {stop_bit && !pbad, !stop_bit, pbad};
    ev_byte[ev] = b;
    inj_en  = 1'b1;
    inj_bit = 1'b0;
    step();
    for (int i = 0; i < DATA_W; i++) begin
      inj_bit = b[i];
      step();
    end
    if (PAR != 0) begin
      inj_bit = (^b) ^ !par_good;
      step();
    end
    inj_bit = stop_bit;
    step();
    inj_bit = 1'b1;
    step();
    inj_en = 1'b0;
    step();
  endtask

  task automatic do_reset();
    Valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("rst_serial_out", 32'(serial_out), 32'(1));
    check("rst_tx_ready", 32'(tx_ready), 32'(1));
    check("rst_data_out", 32'(data_out), 32'(0));
    check("rst_valid_out", 32'(valid_out), 32'(0));
    check("rst_framing_err", 32'(framing_err), 32'(0));
    check("rst_parity_err", 32'(parity_err), 32'(0));
    last_acc  = -1000;
    cur_start = -1000;
    exp_data  = '0;
    ev_kind.delete();
    ev_byte.delete();
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    int t0, t1, t2;
    logic [DATA_W-1:0] keep;
    reset   = 1'b1;
    Valid   = 1'b0;
    DATA    = '0;
    inj_en  = 1'b0;
    inj_bit = 1'b1;
    do_reset();
    repeat (3) step();

    // Single loopback byte with latency measurement.
    send(8'hA5);
    t0 = last_acc;
    drain();
    check("a5_data", 32'(data_out), 32'(8'hA5));
    check("a5_latency", 32'(vcyc - t0), 32'(FRAME));

    // Back-to-back frames at full rate.
    send(8'h00); t0 = last_acc;
    send(8'hFF); t1 = last_acc;
    send(8'h3C); t2 = last_acc;
    drain();
    check("b2b_gap1", 32'(t1 - t0), 32'(FRAME));
    check("b2b_gap2", 32'(t2 - t1), 32'(FRAME));
    check("b2b_last", 32'(data_out), 32'(8'h3C));

    // Backpressure: DATA changes while not ready; only the accept-edge value counts.
    send(8'h44);
    DATA  = 8'h11;
    Valid = 1'b1;
    while (cyc < last_acc + FRAME - 1) step();
    DATA = 8'h22;
    step();
    drain();
    check("bp_data", 32'(data_out), 32'(8'h22));

    // Bad stop bit: framing pulse, data_out untouched.
    keep = data_out;
    inject(8'h5A, 1'b1, 1'b0);
    check("ferr_hold", 32'(data_out), 32'(keep));
    inject(8'h69, 1'b1, 1'b1);
    check("inj_good", 32'(data_out), 32'(8'h69));

`ifdef PARITY_EN
    keep = data_out;
    inject(8'h07, 1'b0, 1'b1);
    check("perr_hold", 32'(data_out), 32'(keep));
    send(8'h07);
    t0 = last_acc;
    drain();
    check("par_data", 32'(data_out), 32'(8'h07));
    check("par_latency", 32'(vcyc - t0), 32'(DATA_W + 3));
`endif

    // Reset in the middle of a frame.
    send(8'hC3);
    repeat (4) step();
    do_reset();
    repeat (FRAME + 3) step();

    // Randomized traffic mixed with injected frames.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        drain();
        inject(DATA_W'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      end else begin
        int gap;
        gap = $urandom_range(0, 3);
        if (gap != 0) begin
          Valid = 1'b0;
          repeat (gap) step();
        end
        if ($urandom_range(0, 1) == 1 && cyc < last_acc + FRAME - 2) begin
          DATA  = DATA_W'($urandom);
          Valid = 1'b1;
          step();
        end
        send(DATA_W'($urandom));
      end
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
